arfs_flow_table: RTL

- Parametrised flow-steering table for the C2H path: maps a 5-tuple key, plus an optional VLAN ID, to a C2H queue ID (qid).
- Lookup port serves the packet parser at one lookup per cycle.
- Command port serves the control-packet decoder: insert/update, delete and flush.
- Adds per-entry idle aging with automatic eviction, plus status reporting, which the first-generation steering logic lacks.

---
 rtl/arfs_flow_table.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/arfs_flow_table.sv
// Fully associative flow-steering table: 5-tuple (+VLAN) -> C2H qid, with
// one-per-cycle lookup, insert/delete/flush command FSM and idle-age eviction.
module arfs_flow_table #(
   parameter int unsigned KEY_W       = 104,
   parameter int unsigned QID_W       = 11,
   parameter int unsigned NUM_ENTRIES = 16,
   parameter int unsigned USE_VLAN    = 1,
   parameter int unsigned DEFAULT_QID = 0,
   parameter int unsigned AGE_W       = 16
) (
   input  logic                                 axis_aclk,
   input  logic                                 axis_aresetn,
   input  logic                                 s_lkp_valid,
   input  logic [KEY_W-1:0]                     s_lkp_key,
   input  logic [11:0]                          s_lkp_vlan,
   output logic                                 s_lkp_ready,
   output logic                                 m_lkp_valid,
   output logic [QID_W-1:0]                     m_lkp_qid,
   output logic                                 m_lkp_hit,
   input  logic                                 m_lkp_ready,
   input  logic                                 s_cmd_valid,
   input  logic [1:0]                           s_cmd_op,
   input  logic [KEY_W-1:0]                     s_cmd_key,
   input  logic [11:0]                          s_cmd_vlan,
   input  logic [QID_W-1:0]                     s_cmd_qid,
   output logic                                 s_cmd_ready,
   output logic                                 m_cmd_done,
   output logic [1:0]                           m_cmd_status,
   input  logic                                 age_tick,
   input  logic [AGE_W-1:0]                     age_limit,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]     occupancy
);

   localparam int unsigned OCC_W = $clog2(NUM_ENTRIES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_WRITE, ST_DONE} state_t;
   typedef enum logic [1:0] {OP_INSERT, OP_DELETE, OP_FLUSH, OP_RSVD} op_t;
   typedef enum logic [1:0] {STS_OK, STS_UPDATED, STS_FULL, STS_INVALID} status_t;

   // table storage
   logic [NUM_ENTRIES-1:0] valid_q, valid_d;
   logic [KEY_W-1:0]       key_q  [NUM_ENTRIES];
   logic [KEY_W-1:0]       key_d  [NUM_ENTRIES];
   logic [11:0]            vlan_q [NUM_ENTRIES];
   logic [11:0]            vlan_d [NUM_ENTRIES];
   logic [QID_W-1:0]       qid_q  [NUM_ENTRIES];
   logic [QID_W-1:0]       qid_d  [NUM_ENTRIES];
   logic [AGE_W-1:0]       age_q  [NUM_ENTRIES];
   logic [AGE_W-1:0]       age_d  [NUM_ENTRIES];
   logic [OCC_W-1:0]       occ_q, occ_d;

   // lookup result stage
   logic                   lkp_valid_q, lkp_valid_d;
   logic                   lkp_hit_q, lkp_hit_d;
   logic [QID_W-1:0]       lkp_qid_q, lkp_qid_d;

   // command FSM
   state_t                 state_q, state_d;
   op_t                    op_q, op_d;
   logic [KEY_W-1:0]       ckey_q, ckey_d;
   logic [11:0]            cvlan_q, cvlan_d;
   logic [QID_W-1:0]       cqid_q, cqid_d;
   logic [NUM_ENTRIES-1:0] cmatch_q, cmatch_d;
   logic                   done_q, done_d;
   status_t                status_q, status_d;
   logic                   cmd_ready_q, cmd_ready_d;

   logic                   lkp_fire;
   logic [NUM_ENTRIES-1:0] lkp_match;
   logic [NUM_ENTRIES-1:0] cmd_match_now;
   logic [QID_W-1:0]       lkp_sel_qid;
   logic [NUM_ENTRIES-1:0] wr_hit_vec, free_vec, free_low;
   logic [NUM_ENTRIES-1:0] wr_set, wr_upd, wr_clr;
   logic                   wr_flush;
   status_t                wr_status;
   logic [AGE_W-1:0]       age_inc;

   assign s_lkp_ready  = !lkp_valid_q || m_lkp_ready;
   assign lkp_fire     = s_lkp_valid && s_lkp_ready;
   assign m_lkp_valid  = lkp_valid_q;
   assign m_lkp_hit    = lkp_hit_q;
   assign m_lkp_qid    = lkp_qid_q;
   assign s_cmd_ready  = cmd_ready_q;
   assign m_cmd_done   = done_q;
   assign m_cmd_status = status_q;
   assign occupancy    = occ_q;

   always_comb begin
      lkp_match     = '0;
      cmd_match_now = '0;
      lkp_sel_qid   = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         lkp_match[i]     = valid_q[i] && (key_q[i] == s_lkp_key) &&
                            ((USE_VLAN == 0) || (vlan_q[i] == s_lkp_vlan));
         cmd_match_now[i] = valid_q[i] && (key_q[i] == ckey_q) &&
                            ((USE_VLAN == 0) || (vlan_q[i] == cvlan_q));
         if (lkp_match[i]) begin
            lkp_sel_qid = lkp_sel_qid | qid_q[i];
         end
      end
   end

   // Match captured in SEARCH is re-qualified with the live valid bits, so an
   // entry aged out before WRITE counts as free rather than as a hit.
   always_comb begin
      wr_hit_vec = cmatch_q & valid_q;
      free_vec   = ~valid_q;
      free_low   = free_vec & (~free_vec + NUM_ENTRIES'(1));
      wr_set     = '0;
      wr_upd     = '0;
      wr_clr     = '0;
      wr_flush   = 1'b0;
      wr_status  = STS_INVALID;
      if (state_q == ST_WRITE) begin
         case (op_q)
            OP_INSERT: begin
               if (|wr_hit_vec) begin
                  wr_upd    = wr_hit_vec;
                  wr_status = STS_UPDATED;
               end else if (|free_vec) begin
                  wr_set    = free_low;
                  wr_status = STS_OK;
               end else begin
                  wr_status = STS_FULL;
               end
            end
            OP_DELETE: begin
               if (|wr_hit_vec) begin
                  wr_clr    = wr_hit_vec;
                  wr_status = STS_OK;
               end
            end
            OP_FLUSH: begin
               wr_flush  = 1'b1;
               wr_status = STS_OK;
            end
            default: wr_status = STS_INVALID;
         endcase
      end
   end

   // Per-entry update, lowest priority first so later assignments win.
   always_comb begin
      valid_d = valid_q;
      key_d   = key_q;
      vlan_d  = vlan_q;
      qid_d   = qid_q;
      age_d   = age_q;
      age_inc = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (age_tick && (age_limit != '0) && valid_q[i]) begin
            age_inc  = (age_q[i] == '1) ? age_q[i] : age_q[i] + AGE_W'(1);
            age_d[i] = age_inc;
            if (age_inc >= age_limit) begin
               valid_d[i] = 1'b0;
            end
         end
         if (lkp_fire && lkp_match[i]) begin
            age_d[i]   = '0;
            valid_d[i] = 1'b1;
         end
         if (wr_flush || wr_clr[i]) begin
            valid_d[i] = 1'b0;
            age_d[i]   = '0;
         end
         if (wr_upd[i]) begin
            valid_d[i] = 1'b1;
            qid_d[i]   = cqid_q;
            age_d[i]   = '0;
         end
         if (wr_set[i]) begin
            valid_d[i] = 1'b1;
            key_d[i]   = ckey_q;
            vlan_d[i]  = cvlan_q;
            qid_d[i]   = cqid_q;
            age_d[i]   = '0;
         end
      end
   end

   always_comb begin
      occ_d = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         occ_d = occ_d + OCC_W'(valid_d[i]);
      end
   end

   always_comb begin
      lkp_valid_d = lkp_valid_q;
      lkp_hit_d   = lkp_hit_q;
      lkp_qid_d   = lkp_qid_q;
      if (lkp_fire) begin
         lkp_valid_d = 1'b1;
         lkp_hit_d   = |lkp_match;
         lkp_qid_d   = (|lkp_match) ? lkp_sel_qid : QID_W'(DEFAULT_QID);
      end else if (m_lkp_ready) begin
         lkp_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      ckey_d   = ckey_q;
      cvlan_d  = cvlan_q;
      cqid_d   = cqid_q;
      status_d = status_q;
      cmatch_d = cmatch_q;
      case (state_q)
         ST_IDLE: begin
            if (s_cmd_valid && cmd_ready_q) begin
               state_d = ST_SEARCH;
               op_d    = op_t'(s_cmd_op);
               ckey_d  = s_cmd_key;
               cvlan_d = s_cmd_vlan;
               cqid_d  = s_cmd_qid;
            end
         end
         ST_SEARCH: begin
            cmatch_d = cmd_match_now;
            state_d  = ST_WRITE;
         end
         ST_WRITE: begin
            status_d = wr_status;
            state_d  = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      done_d      = (state_q == ST_WRITE);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         valid_q     <= '0;
         key_q       <= '{default: '0};
         vlan_q      <= '{default: '0};
         qid_q       <= '{default: '0};
         age_q       <= '{default: '0};
         occ_q       <= '0;
         lkp_valid_q <= 1'b0;
         lkp_hit_q   <= 1'b0;
         lkp_qid_q   <= '0;
         state_q     <= ST_IDLE;
         op_q        <= OP_INSERT;
         ckey_q      <= '0;
         cvlan_q     <= '0;
         cqid_q      <= '0;
         cmatch_q    <= '0;
         done_q      <= 1'b0;
         status_q    <= STS_OK;
         cmd_ready_q <= 1'b1;
      end else begin
         valid_q     <= valid_d;
         key_q       <= key_d;
         vlan_q      <= vlan_d;
         qid_q       <= qid_d;
         age_q       <= age_d;
         occ_q       <= occ_d;
         lkp_valid_q <= lkp_valid_d;
         lkp_hit_q   <= lkp_hit_d;
         lkp_qid_q   <= lkp_qid_d;
         state_q     <= state_d;
         op_q        <= op_d;
         ckey_q      <= ckey_d;
         cvlan_q     <= cvlan_d;
         cqid_q      <= cqid_d;
         cmatch_q    <= cmatch_d;
         done_q      <= done_d;
         status_q    <= status_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

endmodule
